// File: rtl/residual_reconstruct.sv
// Residual reconstruction for one 4x4 block: rebuilds the intra prediction
// (vertical / horizontal / DC) from neighbour pixels, adds the signed residual,
// saturates to the unsigned pixel range and holds the block until acknowledged.
module residual_reconstruct #(
    parameter int PIX_W      = 8,
    parameter int DC_DEFAULT = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [16*PIX_W-1:0]  residual_flat,
    input  logic [1:0]           residual_mode,
    input  logic                 residual_ready,
    input  logic [4*PIX_W-1:0]   top_row,
    input  logic [4*PIX_W-1:0]   left_col,
    input  logic                 neighbour_avail,
    input  logic                 stall,
    input  logic                 recon_ack,
    output logic [16*PIX_W-1:0]  recon_flat,
    output logic [1:0]           recon_mode,
    output logic                 recon_valid,
    output logic                 recon_busy,
    output logic                 mode_error
);

    // Sum of eight neighbours plus rounding needs three extra bits; the
    // residual add needs one bit of headroom and one sign bit.
    localparam int SUM_W = PIX_W + 3;
    localparam int S_W   = PIX_W + 2;

    localparam logic [PIX_W-1:0]        DC_DEF  = PIX_W'(DC_DEFAULT);
    localparam logic signed [S_W-1:0]   PIX_MAX = S_W'((1 << PIX_W) - 1);

    localparam logic [1:0] MODE_VER  = 2'b00;
    localparam logic [1:0] MODE_HOR  = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREDICT = 2'd1,
        ADD     = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    // Captured copies: the block in flight never sees later input changes.
    logic [16*PIX_W-1:0] res_p0;
    logic [4*PIX_W-1:0]  top_p0;
    logic [4*PIX_W-1:0]  left_p0;
    logic [1:0]          mode_p0;
    logic                avail_p0;

    logic [PIX_W-1:0]    dc_val;
    logic [16*PIX_W-1:0] pred_d;
    logic [16*PIX_W-1:0] pred_p1;
    logic [16*PIX_W-1:0] recon_d;

    // Rounded mean of the four top and four left neighbours.
    function automatic logic [PIX_W-1:0] dc_pred(input logic [4*PIX_W-1:0] top,
                                                 input logic [4*PIX_W-1:0] left);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(4);
        for (int k = 0; k < 4; k++) begin
            sum = sum + SUM_W'(top[k*PIX_W +: PIX_W]) + SUM_W'(left[k*PIX_W +: PIX_W]);
        end
        return sum[SUM_W-1:3];
    endfunction

    // Clamp a signed sum into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] sat_pixel(input logic signed [S_W-1:0] s);
        if (s[S_W-1]) begin
            return '0;
        end
        if (s > PIX_MAX) begin
            return '1;
        end
        return s[PIX_W-1:0];
    endfunction

    // Unsigned prediction plus sign-extended residual, then saturate.
    function automatic logic [PIX_W-1:0] add_sat(input logic [PIX_W-1:0] pred,
                                                 input logic [PIX_W-1:0] res);
        logic signed [S_W-1:0] s;
        s = $signed({2'b00, pred}) + $signed({{2{res[PIX_W-1]}}, res});
        return sat_pixel(s);
    endfunction

    // Next-state logic; acceptance only in IDLE and only without stall.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (residual_ready && !stall) begin
                    accept = 1'b1;
                    if (residual_mode != MODE_RSVD) begin
                        state_d = PREDICT;
                    end
                end
            end
            PREDICT: state_d = ADD;
            ADD:     state_d = OUTPUT;
            OUTPUT: begin
                if (recon_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prediction for every pixel (index i = 4*row + col) from captured neighbours.
    always_comb begin
        pred_d = '0;
        dc_val = dc_pred(top_p0, left_p0);
        for (int i = 0; i < 16; i++) begin
            if (!avail_p0) begin
                pred_d[i*PIX_W +: PIX_W] = DC_DEF;
            end else begin
                case (mode_p0)
                    MODE_VER: pred_d[i*PIX_W +: PIX_W] = top_p0[(i % 4)*PIX_W +: PIX_W];
                    MODE_HOR: pred_d[i*PIX_W +: PIX_W] = left_p0[(i / 4)*PIX_W +: PIX_W];
                    default:  pred_d[i*PIX_W +: PIX_W] = dc_val;
                endcase
            end
        end
    end

    // Residual add with saturation for all sixteen pixels.
    always_comb begin
        recon_d = '0;
        for (int i = 0; i < 16; i++) begin
            recon_d[i*PIX_W +: PIX_W] = add_sat(pred_p1[i*PIX_W +: PIX_W],
                                                res_p0[i*PIX_W +: PIX_W]);
        end
    end

    // Stage p0 capture and stage p1 prediction registers (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            res_p0   <= residual_flat;
            top_p0   <= top_row;
            left_p0  <= left_col;
            mode_p0  <= residual_mode;
            avail_p0 <= neighbour_avail;
        end
        if (state_q == PREDICT) begin
            pred_p1 <= pred_d;
        end
    end

    // State register, handshake flags and the held output block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            recon_flat  <= '0;
            recon_mode  <= '0;
            recon_valid <= 1'b0;
            recon_busy  <= 1'b0;
            mode_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_error <= accept && (residual_mode == MODE_RSVD);
            if (accept && (residual_mode != MODE_RSVD)) begin
                recon_busy <= 1'b1;
            end
            if (state_q == ADD) begin
                recon_flat  <= recon_d;
                recon_mode  <= mode_p0;
                recon_valid <= 1'b1;
            end
            if ((state_q == OUTPUT) && recon_ack) begin
                recon_valid <= 1'b0;
                recon_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_residual_reconstruct.sv
// Scoreboard bench for residual_reconstruct: directed cases, randomized blocks
// against a plain-arithmetic reference, backpressure, stall and reset.
module tb_residual_reconstruct;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] residual_flat;
    logic [1:0]   residual_mode;
    logic         residual_ready;
    logic [31:0]  top_row;
    logic [31:0]  left_col;
    logic         neighbour_avail;
    logic         stall;
    logic         recon_ack;
    logic [127:0] recon_flat;
    logic [1:0]   recon_mode;
    logic         recon_valid;
    logic         recon_busy;
    logic         mode_error;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] flat;
        logic [1:0]   mode;
        bit           is_err;
    } exp_t;

    exp_t sb[$];

    residual_reconstruct #(.PIX_W(8), .DC_DEFAULT(128)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .residual_flat   (residual_flat),
        .residual_mode   (residual_mode),
        .residual_ready  (residual_ready),
        .top_row         (top_row),
        .left_col        (left_col),
        .neighbour_avail (neighbour_avail),
        .stall           (stall),
        .recon_ack       (recon_ack),
        .recon_flat      (recon_flat),
        .recon_mode      (recon_mode),
        .recon_valid     (recon_valid),
        .recon_busy      (recon_busy),
        .mode_error      (mode_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: intra prediction + residual, clamped to 0..255, using integers.
    function automatic logic [127:0] ref_block(input logic [127:0] res, input logic [1:0] mode,
                                               input logic [31:0] top, input logic [31:0] left,
                                               input bit avail);
        logic [127:0] out;
        logic [7:0]   rb;
        int dc, pred, v;
        out = '0;
        dc  = 4;
        for (int k = 0; k < 4; k++) dc += int'(top[k*8 +: 8]) + int'(left[k*8 +: 8]);
        dc = dc / 8;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!avail)         pred = 128;
                else if (mode == 0) pred = int'(top[c*8 +: 8]);
                else if (mode == 1) pred = int'(left[r*8 +: 8]);
                else                pred = dc;
                rb = res[(4*r+c)*8 +: 8];
                v  = pred + int'($signed(rb));
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
                out[(4*r+c)*8 +: 8] = 8'(v);
            end
        end
        return out;
    endfunction

    // Monitor: pops one expectation per delivered block or error pulse.
    initial begin
        exp_t e;
        bit   prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mode_error) begin
                    check("mode_error_width", {127'b0, prev_err}, 128'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_mode_error", 128'd1, 128'd0);
                    end else begin
                        e = sb.pop_front();
                        check("error_slot_kind", {127'b0, e.is_err}, 128'd1);
                    end
                end
                if (recon_valid && recon_ack) begin
                    if (sb.size() == 0) begin
                        check("unexpected_block", 128'd1, 128'd0);
                    end else begin
                        e = sb.pop_front();
                        check("block_slot_kind", {127'b0, e.is_err}, 128'd0);
                        check("recon_flat", recon_flat, e.flat);
                        check("recon_mode", {126'b0, recon_mode}, {126'b0, e.mode});
                    end
                end
            end
            prev_err = mode_error;
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        while (recon_busy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check("idle_timeout", 128'd1, 128'd0);
    endtask

    // Issue one block; stall_cyc cycles of stall with ready held first.
    task automatic send_block(input logic [127:0] res, input logic [1:0] mode,
                              input logic [31:0] top, input logic [31:0] left,
                              input bit avail, input int stall_cyc, input logic [127:0] exp_flat);
        exp_t e;
        int   k;
        wait_idle();
        e.flat = exp_flat; e.mode = mode; e.is_err = (mode == 2'b11);
        sb.push_back(e);
        @(negedge clk);
        residual_flat   = res;
        residual_mode   = mode;
        top_row         = top;
        left_col        = left;
        neighbour_avail = avail;
        residual_ready  = 1'b1;
        stall           = (stall_cyc > 0);
        for (int s = 0; s < stall_cyc; s++) begin
            @(posedge clk); #1;
            check("stall_blocks_accept", {126'b0, recon_busy, mode_error}, 128'd0);
        end
        if (stall_cyc > 0) begin
            @(negedge clk);
            stall = 1'b0;
        end
        if (mode == 2'b11) begin
            @(posedge clk); #1;
            residual_ready = 1'b0;
            check("err_busy_low", {127'b0, recon_busy}, 128'd0);
            @(posedge clk); #1;
            check("err_no_valid", {126'b0, recon_valid, mode_error}, 128'd0);
        end else begin
            k = 0;
            while (!recon_busy && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            check("accept_edge", 128'(k), 128'd1);
            residual_ready  = 1'b0;
            residual_flat   = rand128();
            residual_mode   = 2'($urandom_range(0, 3));
            top_row         = $urandom();
            left_col        = $urandom();
            neighbour_avail = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("valid_not_early", {127'b0, recon_valid}, 128'd0);
            @(posedge clk); #1;
            check("valid_latency", {127'b0, recon_valid}, 128'd1);
        end
    endtask

    initial begin
        logic [127:0] r, snap;
        logic [31:0]  t, l;
        logic [1:0]   m;
        bit           a;
        int           k;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] r, snap;
        logic [31:0]  t, l;
        logic [1:0]   m;
        bit           a;
        int           k;

        rst_n = 1'b0; residual_flat = '0; residual_mode = '0; residual_ready = 1'b0;
        top_row = '0; left_col = '0; neighbour_avail = 1'b0; stall = 1'b0; recon_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {recon_flat, recon_mode, recon_valid, recon_busy, mode_error}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vertical
        send_block({16{8'h01}}, 2'b00, {8'd40, 8'd30, 8'd20, 8'd10}, $urandom(), 1'b1, 0,
                   {4{8'd41, 8'd31, 8'd21, 8'd11}});
        // Horizontal with saturation at both ends
        send_block({{4{8'hFB}}, {4{8'h00}}, {4{8'h00}}, {4{8'd100}}}, 2'b01, $urandom(),
                   {8'd0, 8'd50, 8'd100, 8'd200}, 1'b1, 0,
                   {{4{8'd0}}, {4{8'd50}}, {4{8'd100}}, {4{8'd255}}});
        // DC with and without neighbours
        send_block('0, 2'b10, {4{8'd100}}, {4{8'd103}}, 1'b1, 0, {16{8'd102}});
        send_block('0, 2'b10, {4{8'd100}}, {4{8'd103}}, 1'b0, 0, {16{8'd128}});
        // Reserved mode then a normal block
        send_block(rand128(), 2'b11, $urandom(), $urandom(), 1'b1, 0, '0);
        send_block({16{8'h01}}, 2'b00, {8'd40, 8'd30, 8'd20, 8'd10}, $urandom(), 1'b1, 0,
                   {4{8'd41, 8'd31, 8'd21, 8'd11}});
        // Stall in IDLE with ready held
        send_block({16{8'hFF}}, 2'b00, {8'd0, 8'd1, 8'd2, 8'd3}, $urandom(), 1'b1, 3,
                   {4{8'd0, 8'd0, 8'd1, 8'd2}});

        // Backpressure: recon_ack low for ten cycles
        wait_idle();
        recon_ack = 1'b0;
        r = rand128(); t = $urandom(); l = $urandom();
        send_block(r, 2'b01, t, l, 1'b1, 0, ref_block(r, 2'b01, t, l, 1'b1));
        snap = recon_flat;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_flat", recon_flat, snap);
            check("hold_busy_valid", {126'b0, recon_busy, recon_valid}, 128'd3);
        end
        recon_ack = 1'b1;
        @(posedge clk); #1;
        check("ack_release", {126'b0, recon_busy, recon_valid}, 128'd0);
        check("flat_kept_after_ack", recon_flat, snap);

        // Reset while the block is in PREDICT
        wait_idle();
        @(negedge clk);
        residual_flat = rand128(); residual_mode = 2'b00; top_row = $urandom();
        left_col = $urandom(); neighbour_avail = 1'b1; residual_ready = 1'b1;
        k = 0;
        while (!recon_busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("reset_case_accept", 128'(k), 128'd1);
        residual_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_mid_block", {recon_flat, recon_mode, recon_valid, recon_busy, mode_error}, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {126'b0, recon_valid, recon_busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = rand128(); t = $urandom(); l = $urandom();
        send_block(r, 2'b10, t, l, 1'b1, 0, ref_block(r, 2'b10, t, l, 1'b1));

        // Randomized blocks
        for (int n = 0; n < 40; n++) begin
            r = rand128(); t = $urandom(); l = $urandom();
            m = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) != 0);
            send_block(r, m, t, l, a, $urandom_range(0, 2), ref_block(r, m, t, l, a));
        end

        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
